// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// 8N1 UART receiver. The asynchronous rx pin is synchronised, each frame is
// sampled mid-bit and reassembled LSB first, and the byte is handed to the
// consumer through a one-entry valid/ready holding register.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   rx            in   serial line (idle high), asynchronous to clk
//   data[7:0]     out  received byte, meaningful while valid=1
//   valid         out  holding register full
//   ready         in   consumer takes data on a cycle with valid & ready
//   busy          out  high whenever the receive FSM is not idle
//   framing_error out  one-cycle pulse: stop bit sampled low
//   overrun       out  one-cycle pulse: good byte dropped, holding reg full
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       sh_reg, sh_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             fe_reg, fe_next;
  logic             ov_reg, ov_next;
  logic             deliver;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  logic [1:0] sync_reg;
  logic       rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
      sh_reg      <= 8'h00;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      fe_reg      <= 1'b0;
      ov_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      sh_reg      <= sh_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      fe_reg      <= fe_next;
      ov_reg      <= ov_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    sh_next      = sh_reg;
    deliver      = 1'b0;
    fe_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        // Half a bit in: a line that has gone back high was only a glitch.
        if (cnt_reg == HALF_LAST) begin
          if (!rx_s) begin
            state_next   = S_DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_reg == FULL_LAST) begin
          sh_next      = {rx_s, sh_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          // Restart the bit timer while staying in DATA.
          cnt_next     = '0;
          if (bit_idx_reg == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_reg == FULL_LAST) begin
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = S_IDLE;
          end else begin
            fe_next    = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold here while the line is low so a break reports only once.
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (state_next != state_reg) cnt_next = '0;
  end

  // ---------------------------------------------------------------------------
  // Holding register / handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    ov_next    = 1'b0;

    if (valid_reg && ready) valid_next = 1'b0;

    // A byte may load on the same cycle the previous one is taken.
    if (deliver) begin
      if (!valid_reg || ready) begin
        data_next  = sh_reg;
        valid_next = 1'b1;
      end else begin
        ov_next = 1'b1;
      end
    end
  end

  assign data          = data_reg;
  assign valid         = valid_reg;
  assign busy          = (state_reg != S_IDLE);
  assign framing_error = fe_reg;
  assign overrun       = ov_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Self-checking bench for uart_receiver. A fast baud rate keeps frames short
// (CLKS_PER_BIT = 25, HALF_BIT = 12, an odd divisor so the integer division
// of the half-bit point matters). Expected bytes and timings are derived from
// the line protocol: every frame with a high stop bit yields its byte, a low
// stop bit yields one framing error, and latency follows the sampling points.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 2_000_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HB     = CPB / 2;
  localparam int LAT    = HB + 9 * CPB + 3;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       framing_error;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  // Observed traffic, gathered away from the active edge.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic       rand_done;

  uart_receiver #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .busy         (busy),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) got_q.push_back(data);
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; called 1 time unit after a rising edge. A good
  // frame is recorded in the expected queue.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    $display("tx frame byte=%02h stop=%0b", b, stop_bit);
    if (stop_bit) exp_q.push_back(b);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB);
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    rand_done = 1'b0;
    wait_cycles(3);
    checks++;
    if ({data, valid, busy, framing_error, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL reset_held: outputs=%03h expected 000", {data, valid, busy, framing_error, overrun});
    end
    rst = 1'b0;
    wait_cycles(3);
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h expected 00", data); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if ({framing_error, overrun} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00", {framing_error, overrun});
    end
  endtask

  task automatic test_single_byte();
    int n;
    bit seen;
    int fe0, ov0;
    clear_obs();
    fe0   = fe_cnt;
    ov0   = ov_cnt;
    ready = 1'b1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LAT + CPB) begin
          @(posedge clk);
          #2;
          n++;
          if (valid) seen = 1'b1;
        end
        checks++;
        if (!seen || n != LAT) begin
          failures++;
          $display("FAIL single_latency: got %0d cycles (seen=%0b) expected %0d", n, seen, LAT);
        end
        checks++;
        if (data !== 8'h55) begin failures++; $display("FAIL single_data: got %02h expected 55", data); end
        @(posedge clk);
        #2;
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL single_pulse: valid=%b one cycle later, expected 0", valid); end
      end
    join
    wait_cycles(CPB);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      failures++;
      $display("FAIL single_xfer: got %0d transfers expected 1 of 55", got_q.size());
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      failures++;
      $display("FAIL single_flags: fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_glitch();
    int rise_k, fall_k;
    int fe0, ov0;
    clear_obs();
    fe0    = fe_cnt;
    ov0    = ov_cnt;
    rise_k = 0;
    fall_k = 0;
    rx     = 1'b0;
    for (int k = 1; k <= HB + 8; k++) begin
      @(posedge clk);
      #1;
      if (k == HB / 2) rx = 1'b1;
      #1;
      if (busy && rise_k == 0) rise_k = k;
      if (!busy && rise_k != 0 && fall_k == 0) fall_k = k;
    end
    checks++;
    if (rise_k != 3) begin failures++; $display("FAIL glitch_busy_rise: got cycle %0d expected 3", rise_k); end
    checks++;
    if (fall_k != HB + 3) begin failures++; $display("FAIL glitch_busy_fall: got cycle %0d expected %0d", fall_k, HB + 3); end
    wait_cycles(2 * CPB);
    checks++;
    if (got_q.size() != 0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      failures++;
      $display("FAIL glitch_quiet: xfers=%0d fe=%0d ov=%0d expected 0 0 0", got_q.size(), fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_framing_break();
    int fe0;
    clear_obs();
    fe0   = fe_cnt;
    ready = 1'b1;
    send_frame(8'hA3, 1'b0);
    wait_cycles(20 * CPB);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL break_busy: got %b expected 1", busy); end
    checks++;
    if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL break_fe_count: got %0d expected 1", fe_cnt - fe0); end
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL break_no_byte: got %0d transfers expected 0", got_q.size()); end
    rx = 1'b1;
    wait_cycles(4);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL break_release: busy=%b expected 0", busy); end
    send_frame(8'hA3, 1'b1);
    wait_cycles(CPB);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA3) begin
      failures++;
      $display("FAIL framing_recover: got %0d transfers expected 1 of a3", got_q.size());
    end
    checks++;
    if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL framing_single_pulse: got %0d expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    int fe0, ov0;
    clear_obs();
    fe0   = fe_cnt;
    ov0   = ov_cnt;
    ready = 1'b1;
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    wait_cycles(CPB);
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d transfers expected 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      failures++;
      $display("FAIL b2b_flags: fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_overrun();
    int ov0;
    clear_obs();
    ov0   = ov_cnt;
    ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    wait_cycles(CPB);
    checks++;
    if (valid !== 1'b1 || data !== 8'h3C) begin
      failures++;
      $display("FAIL overrun_hold: valid=%b data=%02h expected 1 3c", valid, data);
    end
    checks++;
    if (ov_cnt - ov0 != 1) begin failures++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ov_cnt - ov0); end
    ready = 1'b1;
    wait_cycles(1);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL overrun_drain_valid: got %b expected 0", valid); end
    wait_cycles(2);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      failures++;
      $display("FAIL overrun_drain_xfer: got %0d transfers expected 1 of 3c", got_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int fe0;
    clear_obs();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    wait_cycles(2);
    checks++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      failures++;
      $display("FAIL midrst_preload: valid=%b data=%02h expected 1 11", valid, data);
    end
    fork
      send_frame(8'hF0, 1'b1);
      begin
        wait_cycles(5 * CPB + CPB / 2);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({data, valid, busy, framing_error, overrun} !== 12'h000) begin
          failures++;
          $display("FAIL midrst_async: outputs=%03h expected 000", {data, valid, busy, framing_error, overrun});
        end
        wait_cycles(2);
        rst = 1'b0;
      end
    join
    clear_obs();
    fe0   = fe_cnt;
    ready = 1'b1;
    wait_cycles(CPB);
    send_frame(8'h5A, 1'b1);
    wait_cycles(CPB);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      failures++;
      $display("FAIL midrst_recover: got %0d transfers expected 1 of 5a", got_q.size());
    end
    checks++;
    if (fe_cnt != fe0) begin failures++; $display("FAIL midrst_fe: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_random_stream();
    int fe0, ov0;
    clear_obs();
    fe0       = fe_cnt;
    ov0       = ov_cnt;
    rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          send_frame(8'($urandom_range(0, 255)), 1'b1);
          wait_cycles($urandom_range(0, CPB));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ready = 1'b1;
    wait_cycles(2 * CPB);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count: got %0d transfers expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random_data[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      failures++;
      $display("FAIL random_flags: fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing_break();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
